// File: rtl/pmem_if.sv
// pmem_if: line-oriented memory bus between an initiator and pmem_responder.
//
// Handshake: the initiator raises exactly one of pmem_read / pmem_write.
// It holds that request, pmem_address and pmem_wdata until the cycle where
// pmem_resp is high. pmem_resp is a single-cycle completion pulse.
// A request that is still high in the cycle after pmem_resp starts a new
// transaction. Dropping the request before pmem_resp aborts the
// transaction, and the responder reports this on proto_err.
//
// Signals:
//   pmem_read, pmem_write   initiator -> responder, request strobes
//   pmem_address[31:0]      initiator -> responder, byte address of a 32-byte line
//   pmem_wdata[255:0]       initiator -> responder, write line data
//   pmem_resp               responder -> initiator, completion pulse
//   pmem_rdata[255:0]       responder -> initiator, read line data
//   busy                    responder -> initiator, transaction in progress
//   proto_err               responder -> initiator, sticky protocol-violation flag
interface pmem_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         busy;
  logic         proto_err;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata, busy, proto_err
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata, busy, proto_err
  );
endinterface

// File: rtl/pmem_responder.sv
// pmem_responder: fixed-latency memory model holding 2**INDEX_BITS lines of
// 256 bits each. It accepts one request at a time, waits LATENCY cycles, and
// then pulses pmem_resp.
//
// Ports:
//   clk      sole clock, rising edge
//   rst      synchronous, active-high reset (array contents are preserved)
//   bus      pmem_if.slave: request/response bus (see pmem_if)
//   state_o  debug view of the FSM state (IDLE/BUSY/RESP)
//
// Timing: the request is accepted at edge E0. pmem_resp is high in the
// cycle that follows edge E0+LATENCY. The state returns to IDLE at the next
// edge, so a held request is accepted again one edge later.
module pmem_responder #(
  parameter int LATENCY    = 4,
  parameter int INDEX_BITS = 6
) (
  input  logic       clk,
  input  logic       rst,
  pmem_if.slave      bus,
  output logic [1:0] state_o
);

  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q;
  logic [7:0]              cnt_q;
  logic                    is_write_q;
  logic [INDEX_BITS-1:0]   idx_q;
  logic [255:0]            wdata_q;
  logic [255:0]            rdata_q;
  logic                    resp_q;
  logic                    busy_q;
  logic                    err_q;

  logic [255:0]            mem [LINES];

  // Request of the captured direction; if it drops mid-transaction, abort.
  logic                    req_live;
  assign req_live = is_write_q ? bus.pmem_write : bus.pmem_read;

  // Offset bits and bits above the index do not select a line.
  logic                    unused_addr_bits;
  assign unused_addr_bits = ^{bus.pmem_address[31:INDEX_BITS+5],
                              bus.pmem_address[4:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      is_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      resp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.pmem_read ^ bus.pmem_write) begin
            state_q    <= BUSY;
            busy_q     <= 1'b1;
            cnt_q      <= 8'(LATENCY);
            is_write_q <= bus.pmem_write;
            idx_q      <= bus.pmem_address[INDEX_BITS+4:5];
            wdata_q    <= bus.pmem_wdata;
          end else if (bus.pmem_read && bus.pmem_write) begin
            err_q <= 1'b1;
          end
        end
        BUSY: begin
          if (!req_live) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b1;
          end else if (cnt_q == 8'd1) begin
            state_q <= RESP;
            resp_q  <= 1'b1;
            cnt_q   <= 8'd0;
            // Read data appears together with the pulse. It then holds until
            // the next read completes.
            if (!is_write_q) rdata_q <= mem[idx_q];
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Writes commit on the edge that ends RESP. A reset on that same edge
  // cancels the commit.
  always_ff @(posedge clk) begin
    if (!rst && state_q == RESP && is_write_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign bus.pmem_resp  = resp_q;
  assign bus.pmem_rdata = rdata_q;
  assign bus.busy       = busy_q;
  assign bus.proto_err  = err_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_pmem_responder.sv
module tb_pmem_responder;

  localparam int LAT  = 4;
  localparam int IDXB = 6;
  localparam int NLINES = 64;

  logic       clk;
  logic       rst;
  logic [1:0] state_dbg;

  pmem_if bus ();

  pmem_responder #(.LATENCY(LAT), .INDEX_BITS(IDXB)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
    $fatal(1, "timeout");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  logic [255:0] model_mem [NLINES];
  logic [255:0] exp_q[$];

  function automatic int line_of(input logic [31:0] a);
    return int'((a / 32) % NLINES);
  endfunction

  function automatic logic [255:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom,
            $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise one request, scramble address/data while busy, and wait for
  // pmem_resp. Returns the latency in cycles from the request rise, or -1
  // if the response never arrives.
  task automatic run_txn(input bit wr, input logic [31:0] addr,
                         input logic [255:0] wd,
                         output logic [255:0] rd, output int lat);
    @(negedge clk);
    bus.pmem_read    = !wr;
    bus.pmem_write   = wr;
    bus.pmem_address = addr;
    bus.pmem_wdata   = wd;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.pmem_resp) begin
        lat = i;
        break;
      end
      bus.pmem_address = $urandom;
      bus.pmem_wdata   = rand_line();
    end
    rd = bus.pmem_rdata;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
  endtask

  // Model-tracked write: updates the model only if the response arrived.
  task automatic model_write(input logic [31:0] addr, input logic [255:0] wd,
                             input string name);
    logic [255:0] rd;
    int lat;
    run_txn(1'b1, addr, wd, rd, lat);
    n_checks++;
    if (lat !== LAT + 1) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, LAT + 1);
    end
    if (lat > 0) model_mem[line_of(addr)] = wd;
  endtask

  task automatic model_read(input logic [31:0] addr, input string name);
    logic [255:0] rd;
    logic [255:0] exp;
    int lat;
    exp_q.push_back(model_mem[line_of(addr)]);
    run_txn(1'b0, addr, '0, rd, lat);
    exp = exp_q.pop_front();
    n_checks++;
    if (lat !== LAT + 1) begin
      n_fail++;
      $display("FAIL %s_latency: got %0d cycles, required %0d", name, lat, LAT + 1);
    end
    n_checks++;
    if (rd !== exp) begin
      n_fail++;
      $display("FAIL %s_data: got %h, required %h", name, rd, exp);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.pmem_resp !== 1'b0) begin
      n_fail++; $display("FAIL reset_resp: got %b, required 0", bus.pmem_resp);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b, required 0", bus.busy);
    end
    n_checks++;
    if (bus.proto_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_proto_err: got %b, required 0", bus.proto_err);
    end
    n_checks++;
    if (bus.pmem_rdata !== 256'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h, required 0", bus.pmem_rdata);
    end
    @(negedge clk);
    n_checks++;
    if (bus.pmem_resp !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_resp: got %b, required 0", bus.pmem_resp);
    end
  endtask

  task automatic test_basic();
    model_write(32'h0000_0040, {32{8'hA5}}, "basic_wr");
    model_read(32'h0000_0040, "basic_rd");
  endtask

  task automatic test_alias();
    logic [255:0] x;
    x = rand_line();
    model_write(32'h0000_0020, x, "alias_wr");
    model_read(32'h0000_0820, "alias_hi_bits");
    model_read(32'h0000_003F, "alias_offset");
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int l = 0; l < NLINES; l++) begin
      if (l != 1 && l != 2) model_write(32'(l * 32), rand_line(), "fill_wr");
    end
    for (int k = 0; k < 30; k++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 1) model_write(a, rand_line(), "rand_wr");
      else model_read(a, "rand_rd");
    end
  endtask

  task automatic test_back_to_back();
    int first, second, gap;
    logic [255:0] rd2;
    first = 0; second = 0; gap = 0;
    rd2 = '0;
    @(negedge clk);
    bus.pmem_read    = 1'b1;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = 32'h0000_0040;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.pmem_resp) begin
        if (first == 0) first = i;
        else begin
          second = i;
          rd2 = bus.pmem_rdata;
          break;
        end
      end else if (first != 0 && !bus.busy) begin
        gap++;
      end
    end
    bus.pmem_read = 1'b0;
    n_checks++;
    if (first !== LAT + 1) begin
      n_fail++; $display("FAIL b2b_first: got %0d cycles, required %0d", first, LAT + 1);
    end
    n_checks++;
    if (second - first !== LAT + 2) begin
      n_fail++; $display("FAIL b2b_spacing: got %0d cycles, required %0d", second - first, LAT + 2);
    end
    n_checks++;
    if (gap !== 1) begin
      n_fail++; $display("FAIL b2b_busy_gap: got %0d cycles low, required 1", gap);
    end
    n_checks++;
    if (rd2 !== model_mem[2]) begin
      n_fail++; $display("FAIL b2b_data: got %h, required %h", rd2, model_mem[2]);
    end
  endtask

  task automatic test_both_high();
    int bad;
    bad = 0;
    @(negedge clk);
    bus.pmem_read  = 1'b1;
    bus.pmem_write = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.pmem_resp || bus.busy) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL both_high_idle: got %0d active cycles, required 0", bad);
    end
    n_checks++;
    if (bus.proto_err !== 1'b1) begin
      n_fail++; $display("FAIL both_high_err: got %b, required 1", bus.proto_err);
    end
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.proto_err !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: got %b, required 1", bus.proto_err);
    end
    do_reset();
    n_checks++;
    if (bus.proto_err !== 1'b0) begin
      n_fail++; $display("FAIL err_cleared: got %b, required 0", bus.proto_err);
    end
  endtask

  task automatic test_abort();
    int bad;
    bad = 0;
    @(negedge clk);
    bus.pmem_write   = 1'b1;
    bus.pmem_read    = 1'b0;
    bus.pmem_address = 32'h0000_0040;
    bus.pmem_wdata   = ~model_mem[2];
    repeat (2) @(negedge clk);
    bus.pmem_write = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (bus.pmem_resp) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL abort_resp: got %0d pulses, required 0", bad);
    end
    n_checks++;
    if (bus.proto_err !== 1'b1) begin
      n_fail++; $display("FAIL abort_err: got %b, required 1", bus.proto_err);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_busy: got %b, required 0", bus.busy);
    end
    model_read(32'h0000_0040, "abort_old_data");
    do_reset();
  endtask

  task automatic test_reset_busy();
    int seen;
    model_read(32'h0000_0060, "pre_rst_rd");
    // Reset while BUSY.
    @(negedge clk);
    bus.pmem_write   = 1'b1;
    bus.pmem_address = 32'h0000_0060;
    bus.pmem_wdata   = ~model_mem[3];
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus.pmem_write = 1'b0;
    n_checks++;
    if (bus.pmem_resp !== 1'b0 || bus.busy !== 1'b0 || bus.proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy_outputs: got resp=%b busy=%b err=%b, required 0 0 0",
               bus.pmem_resp, bus.busy, bus.proto_err);
    end
    n_checks++;
    if (bus.pmem_rdata !== 256'd0) begin
      n_fail++; $display("FAIL rst_busy_rdata: got %h, required 0", bus.pmem_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.pmem_resp !== 1'b0) begin
      n_fail++; $display("FAIL rst_busy_no_resp: got %b, required 0", bus.pmem_resp);
    end
    model_read(32'h0000_0060, "rst_busy_line");
    // Reset on the edge that would commit the write (end of RESP).
    @(negedge clk);
    bus.pmem_write   = 1'b1;
    bus.pmem_address = 32'h0000_0060;
    bus.pmem_wdata   = ~model_mem[3];
    seen = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bus.pmem_resp) begin
        seen = 1;
        break;
      end
    end
    rst = 1'b1;
    @(negedge clk);
    bus.pmem_write = 1'b0;
    rst = 1'b0;
    n_checks++;
    if (seen !== 1) begin
      n_fail++; $display("FAIL rst_resp_wait: got %0d, required 1", seen);
    end
    model_read(32'h0000_0060, "rst_resp_line");
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    test_reset();
    test_basic();
    test_alias();
    test_random();
    test_back_to_back();
    test_both_high();
    test_abort();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
